// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle for the branch predictor.
// The master is the pipeline (drives PCs and resolutions); the slave is the predictor.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] fetch_pc;
  logic            predict_taken;
  logic [XLEN-1:0] predict_target;

  logic            update_en;
  logic [XLEN-1:0] update_pc;
  logic            update_taken;
  logic [XLEN-1:0] update_target;
  logic            update_predicted;
  logic [XLEN-1:0] update_pred_target;

  logic            mispredict;
  logic [31:0]     mispredict_count;

  modport master (
    output fetch_pc,
    input  predict_taken, predict_target,
    output update_en, update_pc, update_taken, update_target,
    output update_predicted, update_pred_target,
    input  mispredict, mispredict_count
  );

  modport slave (
    input  fetch_pc,
    output predict_taken, predict_target,
    input  update_en, update_pc, update_taken, update_target,
    input  update_predicted, update_pred_target,
    output mispredict, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational
// fetch lookup, execute-side update and a saturating mispredict counter.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave io_bp
);
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [ENTRIES-1:0]           r_valid;
  logic [ENTRIES-1:0][TAGW-1:0] r_tag;
  logic [ENTRIES-1:0][XLEN-1:0] r_target;
  logic [ENTRIES-1:0][1:0]      r_ctr;
  logic [31:0]                  r_mcnt;

  // Fetch lookup: reads registered state only, so a same-cycle update is not visible.
  logic [IDX-1:0]  w_fidx;
  logic [TAGW-1:0] w_ftag;
  logic            w_fhit;
  logic            w_ptaken;

  assign w_fidx   = io_bp.fetch_pc[IDX+1:2];
  assign w_ftag   = io_bp.fetch_pc[XLEN-1:IDX+2];
  assign w_fhit   = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign w_ptaken = !rst && w_fhit && r_ctr[w_fidx][1];

  assign io_bp.predict_taken  = w_ptaken;
  assign io_bp.predict_target = w_ptaken ? r_target[w_fidx]
                                         : io_bp.fetch_pc + XLEN'(4);

  // Execute update
  logic [IDX-1:0]  w_uidx;
  logic [TAGW-1:0] w_utag;
  logic            w_uhit;
  logic            w_wr_meta;
  logic            w_wr_ctr;
  logic [1:0]      w_ctr_cur;
  logic [1:0]      w_ctr_next;
  logic            w_mis;

  assign w_uidx    = io_bp.update_pc[IDX+1:2];
  assign w_utag    = io_bp.update_pc[XLEN-1:IDX+2];
  assign w_uhit    = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_ctr_cur = r_ctr[w_uidx];

  // Only taken outcomes allocate; a not-taken miss leaves the table alone.
  assign w_wr_meta = io_bp.update_en && io_bp.update_taken;
  assign w_wr_ctr  = io_bp.update_en && (w_uhit || io_bp.update_taken);

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (!w_uhit) begin
      w_ctr_next = 2'b10;
    end else if (io_bp.update_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
    end
  end

  assign w_mis = io_bp.update_en &&
                 ((io_bp.update_predicted != io_bp.update_taken) ||
                  (io_bp.update_predicted && io_bp.update_taken &&
                   (io_bp.update_pred_target != io_bp.update_target)));

  assign io_bp.mispredict       = w_mis;
  assign io_bp.mispredict_count = r_mcnt;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    logic w_sel;
    assign w_sel = (w_uidx == IDX'(g));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid[g]  <= 1'b0;
        r_tag[g]    <= '0;
        r_target[g] <= '0;
        r_ctr[g]    <= 2'b01;
      end else if (w_sel) begin
        if (w_wr_meta) begin
          r_valid[g]  <= 1'b1;
          r_tag[g]    <= w_utag;
          r_target[g] <= io_bp.update_target;
        end
        if (w_wr_ctr) r_ctr[g] <= w_ctr_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcnt <= '0;
    end else if (w_mis && (r_mcnt != 32'hFFFF_FFFF)) begin
      r_mcnt <= r_mcnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench: stimulus pushes hand-computed expectations into a
// queue; a negedge monitor pops and compares against the predictor outputs.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(32)) bp();

  branch_predictor #(.ENTRIES(64), .XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bp (bp)
  );

  typedef struct {
    int          id;
    logic        taken;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vid     = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d actual=%h required=%h", name, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("predict_taken",    e.id, 32'(bp.predict_taken), 32'(e.taken));
      chk("predict_target",   e.id, bp.predict_target,     e.tgt);
      chk("mispredict",       e.id, 32'(bp.mispredict),    32'(e.mis));
      chk("mispredict_count", e.id, bp.mispredict_count,   e.cnt);
    end
  end

  // One cycle: drive just after the edge, expectation sampled at the next negedge.
  task automatic cyc(input logic r, input logic [31:0] f,
                     input logic en, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utgt, input logic up, input logic [31:0] uptgt,
                     input logic et, input logic [31:0] etg, input logic em,
                     input logic [31:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst                   = r;
    bp.fetch_pc           = f;
    bp.update_en          = en;
    bp.update_pc          = upc;
    bp.update_taken       = ut;
    bp.update_target      = utgt;
    bp.update_predicted   = up;
    bp.update_pred_target = uptgt;
    e.id = vid; e.taken = et; e.tgt = etg; e.mis = em; e.cnt = ec;
    q.push_back(e);
    vid++;
  endtask

  initial begin
    rst = 1'b1;
    bp.fetch_pc = '0; bp.update_en = 1'b0; bp.update_pc = '0; bp.update_taken = 1'b0;
    bp.update_target = '0; bp.update_predicted = 1'b0; bp.update_pred_target = '0;

    //  rst fetch      en upc       t  utgt     p  ptgt      | taken tgt      mis cnt
    cyc(1, 32'h100, 0, 32'h000, 0, 32'h00, 0, 32'h00,   0, 32'h104, 0, 0);   // in reset
    cyc(1, 32'h100, 0, 32'h000, 0, 32'h00, 0, 32'h00,   0, 32'h104, 0, 0);
    cyc(0, 32'h100, 0, 32'h000, 0, 32'h00, 0, 32'h00,   0, 32'h104, 0, 0);
    cyc(0, 32'h400, 1, 32'h400, 0, 32'h00, 0, 32'h00,   0, 32'h404, 0, 0);
    cyc(0, 32'h400, 0, 32'h000, 0, 32'h00, 0, 32'h00,   0, 32'h404, 0, 0);   // no alloc
    cyc(0, 32'h200, 1, 32'h100, 1, 32'h80, 0, 32'h00,   0, 32'h204, 1, 0);
    cyc(0, 32'h100, 0, 32'h000, 0, 32'h00, 0, 32'h00,   1, 32'h080, 0, 1);
    cyc(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80,   1, 32'h080, 0, 1);   // ctr 11
    cyc(0, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80,   1, 32'h080, 0, 1);   // sat 11
    cyc(0, 32'h100, 1, 32'h100, 0, 32'h00, 1, 32'h80,   1, 32'h080, 1, 1);   // ->10
    cyc(0, 32'h100, 0, 32'h000, 0, 32'h00, 0, 32'h00,   1, 32'h080, 0, 2);
    cyc(0, 32'h100, 1, 32'h100, 0, 32'h00, 1, 32'h80,   1, 32'h080, 1, 2);   // ->01
    cyc(0, 32'h100, 0, 32'h000, 0, 32'h00, 0, 32'h00,   0, 32'h104, 0, 3);
    cyc(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h00,   0, 32'h104, 1, 3);   // ->10
    cyc(0, 32'h100, 0, 32'h000, 0, 32'h00, 0, 32'h00,   1, 32'h080, 0, 4);
    cyc(0, 32'h100, 1, 32'h200, 1, 32'h40, 0, 32'h00,   1, 32'h080, 1, 4);   // alias replace
    cyc(0, 32'h100, 0, 32'h000, 0, 32'h00, 0, 32'h00,   0, 32'h104, 0, 5);
    cyc(0, 32'h200, 0, 32'h000, 0, 32'h00, 0, 32'h00,   1, 32'h040, 0, 5);
    cyc(0, 32'h200, 1, 32'h200, 1, 32'h40, 1, 32'h44,   1, 32'h040, 1, 5);   // target mismatch
    cyc(0, 32'h300, 1, 32'h300, 1, 32'h20, 0, 32'h00,   0, 32'h304, 1, 6);   // same-cycle install
    cyc(0, 32'h300, 0, 32'h000, 0, 32'h00, 0, 32'h00,   1, 32'h020, 0, 7);
    cyc(0, 32'h404, 1, 32'h404, 0, 32'h00, 1, 32'h00,   0, 32'h408, 1, 7);   // miss not-taken
    cyc(0, 32'h300, 0, 32'h000, 0, 32'h00, 1, 32'h00,   1, 32'h020, 0, 8);   // en=0 gates
    cyc(0, 32'h300, 1, 32'h300, 0, 32'h00, 1, 32'h20,   1, 32'h020, 1, 8);   // ->01
    cyc(0, 32'h300, 1, 32'h300, 0, 32'h00, 1, 32'h20,   0, 32'h304, 1, 9);   // ->00
    cyc(0, 32'h300, 1, 32'h300, 0, 32'h00, 1, 32'h20,   0, 32'h304, 1, 10);  // sat 00
    cyc(0, 32'h300, 1, 32'h300, 1, 32'h20, 0, 32'h00,   0, 32'h304, 1, 11);  // ->01
    cyc(0, 32'h300, 0, 32'h000, 0, 32'h00, 0, 32'h00,   0, 32'h304, 0, 12);
    cyc(0, 32'h300, 1, 32'h300, 1, 32'h20, 1, 32'h20,   0, 32'h304, 0, 12);  // ->10
    cyc(0, 32'h300, 0, 32'h000, 0, 32'h00, 0, 32'h00,   1, 32'h020, 0, 12);
    cyc(1, 32'h300, 1, 32'h100, 1, 32'h80, 0, 32'h00,   0, 32'h304, 1, 0);   // rst mid-cycle
    cyc(1, 32'h300, 1, 32'h100, 1, 32'h80, 0, 32'h00,   0, 32'h304, 1, 0);   // update dropped
    cyc(0, 32'h100, 0, 32'h000, 0, 32'h00, 0, 32'h00,   0, 32'h104, 0, 0);
    cyc(0, 32'h300, 0, 32'h000, 0, 32'h00, 0, 32'h00,   0, 32'h304, 0, 0);
    cyc(0, 32'h200, 0, 32'h000, 0, 32'h00, 0, 32'h00,   0, 32'h204, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor that consumes branch resolution from the execute stage.
- Holds a direct-mapped branch target buffer: valid bit, tag, target address and a 2-bit saturating direction counter per entry.
- Fetch looks up the current PC combinationally to obtain a predicted direction and next PC.
- Execute writes back the resolved outcome; the block flags mispredictions and keeps a running mispredict count.

Parameters:
ENTRIES, 64, number of BTB entries; must be a power of two; IDX = log2(ENTRIES).
XLEN, 32, address width.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-high reset
fetch_pc  input  XLEN  PC being fetched this cycle
predict_taken  output  1  predicted direction for fetch_pc
predict_target  output  XLEN  predicted next PC for fetch_pc
update_en  input  1  a conditional branch resolves in execute this cycle
update_pc  input  XLEN  PC of the resolving branch
update_taken  input  1  resolved direction from the execute branch comparator
update_target  input  XLEN  resolved branch target address
update_predicted  input  1  direction predicted for this branch at fetch, carried down the pipe
update_pred_target  input  XLEN  target predicted at fetch, carried down the pipe
mispredict  output  1  combinational; execute must redirect and flush
mispredict_count  output  32  registered, saturating count of mispredictions

Behaviour:
- Address split: index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]; pc[1:0] ignored.
- Hit: valid[index] set and tag[index] equals the tag of the PC being looked up.
- Lookup, combinational from registered state only:
  - predict_taken = hit && counter[index][1].
  - predict_target = predict_taken ? target[index] : fetch_pc + 4.
- Update on a rising clk edge when update_en=1:
  - Hit, taken: counter increments, saturating at 11; target[index] is written with update_target.
  - Hit, not taken: counter decrements, saturating at 00; target is unchanged.
  - Miss, taken: the entry is allocated or replaced. valid=1, tag written, target written, counter set to 10 (weakly taken).
  - Miss, not taken: no state change; no allocation.
- Mispredict:
  - mispredict = update_en && ((update_predicted != update_taken) || (update_predicted && update_taken && update_pred_target != update_target)).
  - It depends only on the update inputs, so it has zero latency.
  - update_en=0 forces mispredict=0.
- mispredict_count increments on each rising edge where mispredict=1, and holds at 0xFFFFFFFF.
- Same-cycle lookup and update on the same index:
  - The lookup sees the pre-update state; there is no bypass.
  - The new state is visible to lookups from the cycle after the edge.
- Aliasing: two PCs with the same index but different tags replace each other. Only a taken update replaces an entry.
- Reset, asynchronous and effective immediately regardless of clk:
  - All valid=0, all counters=01, all targets=0, mispredict_count=0.
  - While rst=1, predict_taken=0 and predict_target=fetch_pc+4.
  - Updates presented during reset are dropped; mispredict still reflects its inputs combinationally.
- Update latency is 1 cycle: storage is written at the edge, and tables are registers.

Test Plan (ENTRIES=64, so index=pc[7:2], tag=pc[31:8]):
1. Reset, then fetch_pc=0x100 -> predict_taken=0, predict_target=0x104, mispredict_count=0. Next, update_en, pc=0x400, taken=0, predicted=0 -> mispredict=0. Then fetch_pc=0x400 -> not taken, target 0x404.
2. Update_en, pc=0x100, taken=1, target=0x80, predicted=0 -> mispredict=1 in that cycle. Next cycle: fetch_pc=0x100 gives predict_taken=1, predict_target=0x80, and mispredict_count=1.
3. Continuing from 2:
   - Two taken updates at 0x100 drive the counter to 11.
   - One not-taken update -> still predicts taken (counter 10).
   - A second not-taken update -> predict_taken=0, target 0x104.
   - Each not-taken update presented with predicted=1 raises mispredict, giving count=3.
4. Alias: with 0x100 installed, a taken update at pc=0x200 with target 0x40 -> fetch 0x100 predicts not taken (tag miss); fetch 0x200 predicts taken with target 0x40. A taken update at 0x200 with predicted=1 and pred_target=0x44 -> mispredict=1 (target mismatch).
5. Same cycle: fetch_pc=0x300 while update_en installs 0x300 as taken to 0x20 -> predict_taken=0 that cycle, then 1 with target 0x20 on the following cycle.
6. After count>0 and installed entries, assert rst mid-cycle between edges -> predict_taken=0 and mispredict_count=0 immediately. After release, previously installed PCs predict not taken.
